rom_stream_reader: RTL and testbench

//  Read initiator for the 16x16 synchronous ROM (rom: clk, r_en, addr, data). On a start

---
 rtl/rom_stream_reader_pkg.sv | 14 +
 rtl/rom_stream_reader_if.sv | 18 +
 rtl/rom_stream_reader_fifo.sv | 54 +++++
 rtl/rom_stream_reader.sv | 119 +++++++++++
 tb/tb_rom_stream_reader.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/rom_stream_reader_pkg.sv
// Shared constants for the ROM stream reader slice.
//   ADDR_W / DATA_W : geometry of the 16x16 synchronous ROM
//   ST_*            : reader FSM encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3)
package rom_if_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/rom_stream_reader_if.sv
// Valid/ready word stream with a last flag.
//   m_valid : word present (master -> slave)
//   m_data  : word         (master -> slave)
//   m_last  : final word of a block, qualified by m_valid (master -> slave)
//   m_ready : slave accepts when m_valid && m_ready (slave -> master)
interface rom_stream_reader_if #(
    parameter int DATA_W = 16
);

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    modport master (output m_valid, output m_data, output m_last, input  m_ready);
    modport slave  (input  m_valid, input  m_data, input  m_last, output m_ready);

endinterface

// File: rtl/rom_stream_reader_fifo.sv
// rom_rd_fifo: small synchronous FIFO holding captured ROM words plus their last flag.
//   clk, rst_n : clock, async active-low reset (empties the FIFO, zeroes storage)
//   push_i     : write din_i this cycle
//   din_i      : entry to write
//   pop_i      : drop head entry this cycle (ignored when empty)
//   dout_o     : head entry (storage is zeroed at reset, so 0 when never written)
//   count_o    : number of stored entries
//   empty_o    : count_o == 0
module rom_rd_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 17,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    count_q;
    logic             pop_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign dout_o  = mem_q[rd_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: walks a block of ROM words from base_addr and streams them out.
//   clk, rst_n          : clock, async active-low reset
//   start               : 1-cycle command, sampled only in IDLE
//   base_addr, len      : block start address and word count (0..2**ADDR_W)
//   busy, done          : busy in RUN/DRAIN; done is a 1-cycle pulse in DONE
//   rom_r_en, rom_addr  : ROM read request (data returns one cycle later)
//   rom_data            : ROM read data
//   m_if                : output word stream (valid/ready/last)
module rom_stream_reader #(
    parameter int ADDR_W = rom_if_pkg::ADDR_W,
    parameter int DATA_W = rom_if_pkg::DATA_W,
    parameter int FIFO_D = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     len,
    output logic                busy,
    output logic                done,
    output logic                rom_r_en,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_data,
    rom_stream_reader_if.master m_if
);

    import rom_if_pkg::*;

    localparam int CW = $clog2(FIFO_D + 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic              inflight_q, inflight_last_q;
    logic              issue, pop;
    logic              head_last, fifo_empty;
    logic [DATA_W-1:0] head_data;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       used, limit;

    assign pop = !fifo_empty && m_if.m_ready;

    // Credit: a slot freed by this cycle's pop is reusable now, which is what
    // sustains one word per cycle with only FIFO_D entries of buffering. With
    // m_ready low this still caps outstanding reads at FIFO_D.
    assign used  = {1'b0, fifo_count} + (CW+1)'(inflight_q);
    assign limit = (CW+1)'(FIFO_D) + (CW+1)'(pop);
    assign issue = (state_q == ST_RUN) && (rem_q != '0) && (used < limit);

    assign rom_r_en = issue;
    assign rom_addr = issue ? ptr_q : addr_q;   // hold last issued address otherwise
    assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done     = (state_q == ST_DONE);

    assign m_if.m_valid = !fifo_empty;
    assign m_if.m_data  = head_data;
    assign m_if.m_last  = !fifo_empty && head_last;

    rom_rd_fifo #(
        .DEPTH (FIFO_D),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inflight_q),
        .din_i   ({inflight_last_q, rom_data}),
        .pop_i   (pop),
        .dout_o  ({head_last, head_data}),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ptr_d   = base_addr;
                    rem_d   = len;
                    state_d = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    ptr_d = ptr_q + 1'b1;           // wraps modulo 2**ADDR_W
                    rem_d = rem_q - 1'b1;
                    if (rem_q == (ADDR_W+1)'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The last-flagged word is always the final buffered entry.
                if (pop && head_last) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            ptr_q           <= '0;
            rem_q           <= '0;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            rem_q           <= rem_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && (rem_q == (ADDR_W+1)'(1));
            if (issue) addr_q <= ptr_q;
        end
    end

endmodule

// File: tb/tb_rom_stream_reader.sv
module tb_rom_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  base_addr;
    logic [4:0]  len;
    logic        busy, done, rom_r_en;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;

    rom_stream_reader_if #(.DATA_W(16)) sif ();

    rom_stream_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .rom_r_en  (rom_r_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .m_if      (sif)
    );

    always #5 clk = ~clk;

    // ROM model (synchronous read) and reference contents
    logic [15:0] mem [16];
    always @(posedge clk) if (rom_r_en) rom_data <= mem[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sampled on the falling edge, away from the active edge
    logic [16:0] got_q [$];
    int          acc_cyc_q [$];
    logic [3:0]  addr_q [$];
    int          rd_cnt = 0, done_cnt = 0, done_cyc = 0, stab_err = 0;
    logic        hold_q = 1'b0;
    logic [16:0] hold_v = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_q <= 1'b0;
        end else begin
            if (hold_q && !(sif.m_valid && ({sif.m_last, sif.m_data} == hold_v)))
                stab_err <= stab_err + 1;
            hold_q <= sif.m_valid && !sif.m_ready;
            hold_v <= {sif.m_last, sif.m_data};
            if (sif.m_valid && sif.m_ready) begin
                got_q.push_back({sif.m_last, sif.m_data});
                acc_cyc_q.push_back(cyc);
            end
            if (rom_r_en) begin
                rd_cnt <= rd_cnt + 1;
                addr_q.push_back(rom_addr);
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
    end

    int n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: block = mem[(base+i) mod 16], last on i == len-1
    task automatic check_stream(input string tag, input int mark, input int base, input int len_v);
        logic [16:0] e;
        check({tag, "_count"}, 32'(got_q.size() - mark), 32'(len_v));
        for (int i = 0; i < len_v; i++) begin
            if (mark + i < got_q.size()) begin
                e = {(i == len_v - 1), mem[(base + i) % 16]};
                check({tag, "_word"}, 32'(got_q[mark + i]), 32'(e));
            end
        end
    endtask

    // mode 0: m_ready=1; 1: random m_ready; 2: m_ready low for 5 cycles then high
    task automatic run_block(input string tag, input int base, input int len_v, input int mode,
                             input int mid, output int sc, output int mark, output int amark);
        int rd0, d0;
        bit seen;
        mark  = got_q.size();
        amark = addr_q.size();
        rd0   = rd_cnt;
        d0    = done_cnt;
        seen  = 0;
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = 4'(base);
        len       = 5'(len_v);
        sif.m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
        sc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (done_cnt != d0) begin
                seen = 1;
                break;
            end
            if (mode == 2 && k == 5) begin
                check({tag, "_stall_reads"}, 32'(rd_cnt - rd0), 32'd2);
                check({tag, "_stall_valid"}, 32'(sif.m_valid), 32'd1);
            end
            start = (k == mid);
            if (k == mid) begin
                base_addr = 4'd3;
                len       = 5'd2;
            end
            if (mode == 1)      sif.m_ready = ($urandom_range(0, 3) != 0);
            else if (mode == 2) sif.m_ready = (k >= 5);
            else                sif.m_ready = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        sif.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_reads"}, 32'(rd_cnt - rd0), 32'(len_v));
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check_stream(tag, mark, base, len_v);
        if (len_v > 0 && got_q.size() >= mark + len_v)
            check({tag, "_done_lat"}, 32'(done_cyc), 32'(acc_cyc_q[mark + len_v - 1] + 1));
    endtask

    initial begin
        int sc, mk, am, r0, dl;
        for (int i = 0; i < 16; i++) mem[i] = 16'(16'h1000 + i);
        mem[0]  = 16'h0103; mem[1]  = 16'h5200; mem[2]  = 16'he0b9; mem[3]  = 16'h2468;
        mem[4]  = 16'h1113; mem[5]  = 16'h0112; mem[6]  = 16'h7777; mem[7]  = 16'h8888;
        mem[8]  = 16'hcafe; mem[9]  = 16'h6225; mem[10] = 16'h1447; mem[11] = 16'haeec;
        mem[12] = 16'h52dd; mem[13] = 16'h3333; mem[14] = 16'h4444; mem[15] = 16'h5555;

        rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; sif.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   32'(busy),         32'd0);
        check("rst_done",   32'(done),         32'd0);
        check("rst_ren",    32'(rom_r_en),     32'd0);
        check("rst_addr",   32'(rom_addr),     32'd0);
        check("rst_valid",  32'(sif.m_valid),  32'd0);
        check("rst_last",   32'(sif.m_last),   32'd0);
        check("rst_data",   32'(sif.m_data),   32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: basic block, full throughput
        run_block("t1", 0, 3, 0, -1, sc, mk, am);
        if (acc_cyc_q.size() >= mk + 3) begin
            check("t1_first_lat", 32'(acc_cyc_q[mk] - sc), 32'd3);
            check("t1_back2back", 32'(acc_cyc_q[mk + 2] - acc_cyc_q[mk]), 32'd2);
        end

        // 2: address wrap
        run_block("t2", 14, 4, 0, -1, sc, mk, am);
        for (int i = 0; i < 4; i++)
            if (am + i < addr_q.size())
                check("t2_addr", 32'(addr_q[am + i]), 32'((14 + i) % 16));

        // 3: back-pressure
        run_block("t3", 8, 4, 2, -1, sc, mk, am);

        // 4: zero length
        run_block("t4", 7, 0, 0, -1, sc, mk, am);
        dl = done_cyc - sc;
        check("t4_done_window", 32'(dl >= 1 && dl <= 3), 32'd1);

        // 5: full ROM with wrap, random ready, stray start mid-run
        run_block("t5", 5, 16, 1, 4, sc, mk, am);

        // 6: reset mid-block
        r0 = rd_cnt;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 4'd0; len = 5'd8; sif.m_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy",  32'(busy),        32'd0);
        check("t6_rst_ren",   32'(rom_r_en),    32'd0);
        check("t6_rst_addr",  32'(rom_addr),    32'd0);
        check("t6_rst_valid", 32'(sif.m_valid), 32'd0);
        check("t6_rst_data",  32'(sif.m_data),  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sif.m_ready = 1'b1;
        r0 = rd_cnt;
        repeat (4) @(posedge clk);
        #1;
        check("t6_idle_busy",  32'(busy),          32'd0);
        check("t6_idle_reads", 32'(rd_cnt - r0),   32'd0);
        check("t6_idle_valid", 32'(sif.m_valid),   32'd0);
        run_block("t6", 12, 1, 0, -1, sc, mk, am);

        // randomized blocks against the reference
        for (int r = 0; r < 8; r++)
            run_block("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 16)), 1, -1, sc, mk, am);

        check("stable_hold", 32'(stab_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
